acelp_pulse_enc: RTL and testbench

Encoder-side counterpart of the ACELP fixed-codebook decode stage. It scans the 40-sample fixed-codebook code vector held in scratch memory, locates the four signed pulses, and packs them into the G.729 13-bit pulse-position index and 4-bit sign word. It shares the scratch-memory read port, with one-cycle synchronous read latency, with the other encoder stages through the top-level address mux.

---
 rtl/acelp_pulse_enc_if.sv | 34 +++
 rtl/acelp_pulse_enc.sv | 148 ++++++++++++++
 tb/tb_acelp_pulse_enc.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acelp_pulse_enc_if.sv
// Bus bundle between the pulse encoder and its controller / scratch-memory port.
// Latency: n/a (wiring only).
// Backpressure: none; start is a single-cycle request, done a single-cycle pulse.
interface acelp_pulse_enc_if;
  logic        start;
  logic        done;
  logic [11:0] scratch_mem_read_addr;
  logic [31:0] scratch_mem_in;
  logic [15:0] index;
  logic [15:0] sign;
  logic        error;

  // Controller side: issues start, returns read data, consumes the result.
  modport master (
    output start,
    output scratch_mem_in,
    input  done,
    input  scratch_mem_read_addr,
    input  index,
    input  sign,
    input  error
  );

  // Encoder side.
  modport slave (
    input  start,
    input  scratch_mem_in,
    output done,
    output scratch_mem_read_addr,
    output index,
    output sign,
    output error
  );
endinterface

// File: rtl/acelp_pulse_enc.sv
// Scans the 40-sample fixed-codebook vector and packs the 4 pulses into the 13-bit index + 4-bit sign word.
// Latency: done 42 cycles after start is sampled; 43-cycle back-to-back throughput.
// Backpressure: none; start is ignored outside IDLE, the result is held until the next done.
module acelp_pulse_enc #(
  parameter logic [11:0] CODE_ADDR = 12'd0,
  parameter int          L_SUBFR   = 40
) (
  input  logic              clk,
  input  logic              reset,
  acelp_pulse_enc_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [5:0] LAST_ADDR = 6'(L_SUBFR - 1);

  logic [1:0]  state;
  logic [5:0]  addr_cnt;
  logic        drain_cnt;

  // Read pipeline: an address issued this cycle has its data on
  // scratch_mem_in during the next cycle, consumed at the end of it.
  logic        issue;
  logic        data_vld;

  // Track / in-track position of the sample currently on scratch_mem_in.
  logic [2:0]  trk;
  logic [2:0]  pos_q;

  logic [12:0] idx_acc;
  logic [3:0]  sgn_acc;
  logic [3:0]  found;
  logic        err_acc;

  logic [15:0] smp;
  logic        is_pulse;
  logic        pol;
  logic [1:0]  slot;

  assign bus.scratch_mem_read_addr = CODE_ADDR + {6'd0, addr_cnt};

  // Address 39 is still driven in the first DRAIN cycle.
  assign issue = (state == SCAN) || ((state == DRAIN) && !drain_cnt);

  assign smp      = bus.scratch_mem_in[15:0];
  assign is_pulse = |smp;
  assign pol      = ~smp[15];
  // Tracks 3 and 4 share the last pulse slot.
  assign slot     = (trk >= 3'd3) ? 2'd3 : trk[1:0];

  // Sequencer: address counter and state transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_cnt  <= 6'd0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr_cnt <= 6'd0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          addr_cnt <= addr_cnt + 6'd1;
          if (addr_cnt == LAST_ADDR - 6'd1) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        default: begin
          addr_cnt <= 6'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Data-valid flag aligned with scratch_mem_in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_vld <= 1'b0;
    else       data_vld <= issue;
  end

  // Pulse accumulation: per-slot position/sign fields, found flags, duplicate detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk     <= 3'd0;
      pos_q   <= 3'd0;
      idx_acc <= 13'd0;
      sgn_acc <= 4'd0;
      found   <= 4'd0;
      err_acc <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      trk     <= 3'd0;
      pos_q   <= 3'd0;
      idx_acc <= 13'd0;
      sgn_acc <= 4'd0;
      found   <= 4'd0;
      err_acc <= 1'b0;
    end else if (data_vld) begin
      if (trk == 3'd4) begin
        trk   <= 3'd0;
        pos_q <= pos_q + 3'd1;
      end else begin
        trk <= trk + 3'd1;
      end
      if (is_pulse) begin
        if (found[slot]) err_acc <= 1'b1;
        found[slot]   <= 1'b1;
        sgn_acc[slot] <= pol;
        case (trk)
          3'd0:    idx_acc[2:0]  <= pos_q;
          3'd1:    idx_acc[5:3]  <= pos_q;
          3'd2:    idx_acc[8:6]  <= pos_q;
          3'd3:    idx_acc[12:9] <= {pos_q, 1'b0};
          default: idx_acc[12:9] <= {pos_q, 1'b1};
        endcase
      end
    end
  end

  // Result registers, loaded once per scan on leaving DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.done  <= 1'b0;
      bus.index <= 16'd0;
      bus.sign  <= 16'd0;
      bus.error <= 1'b0;
    end else if (state == DONE) begin
      bus.done  <= 1'b1;
      bus.index <= {3'b000, idx_acc};
      bus.sign  <= {12'd0, sgn_acc};
      bus.error <= err_acc | ~(&found);
    end else begin
      bus.done  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acelp_pulse_enc.sv
// Self-checking bench for acelp_pulse_enc against a position-arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_acelp_pulse_enc;

  localparam logic [11:0] BASE = 12'h100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  acelp_pulse_enc_if bus();

  acelp_pulse_enc #(.CODE_ADDR(BASE), .L_SUBFR(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Scratch memory with one-cycle synchronous read; code vector at BASE.
  logic [31:0] code [40];
  logic [31:0] mem_rd;
  int          mem_off;
  always @(posedge clk) begin
    mem_off = int'(bus.scratch_mem_read_addr) - int'(BASE);
    if (mem_off >= 0 && mem_off < 40) mem_rd <= code[mem_off];
    else                              mem_rd <= $urandom;
  end
  assign bus.scratch_mem_in = mem_rd;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Fresh all-zero vector; upper halves random so they must be ignored.
  task automatic clear_code();
    logic [15:0] r;
    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      code[i] = {r, 16'h0000};
    end
  endtask

  task automatic put(input int p, input logic [15:0] v);
    code[p][15:0] = v;
  endtask

  // Reference: direct position arithmetic (p / 5, p % 5) over the whole vector.
  logic [15:0] exp_idx, exp_sgn;
  logic        exp_err;
  task automatic ref_model();
    int cnt [4];
    int t, q, s, fld, sh, w;
    logic [15:0] v;
    exp_idx = 16'd0;
    exp_sgn = 16'd0;
    exp_err = 1'b0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int p = 0; p < 40; p++) begin
      v = code[p][15:0];
      if (v != 16'd0) begin
        t = p % 5;
        q = p / 5;
        s = (t < 3) ? t : 3;
        if (cnt[s] > 0) exp_err = 1'b1;
        cnt[s]++;
        if (t < 3) begin fld = q;             sh = 3 * t; w = 7;  end
        else       begin fld = 2 * q + t - 3; sh = 9;     w = 15; end
        exp_idx = (exp_idx & ~16'(w << sh)) | 16'(fld << sh);
        exp_sgn[s] = ~v[15];
      end
    end
    for (int k = 0; k < 4; k++) if (cnt[k] == 0) exp_err = 1'b1;
  endtask

  // One start pulse; checks address order, latency, result and done width.
  task automatic run_scan(input string tag, input bit addr_chk, input bit extra_start);
    int n, got, extra;
    ref_model();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0;
    got = -1;
    while (n <= 60) begin
      if (extra_start) bus.start = (n == 5 || n == 20 || n == 41);
      if (addr_chk && n < 40) check({tag, "/addr"}, 32'(bus.scratch_mem_read_addr), 32'(BASE + 12'(n)));
      if (bus.done) begin
        got = n;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check({tag, "/latency"}, 32'(got), 32'd42);
    check({tag, "/index"}, 32'(bus.index), 32'(exp_idx));
    check({tag, "/sign"},  32'(bus.sign),  32'(exp_sgn));
    check({tag, "/error"}, 32'(bus.error), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, "/done_width"}, 32'(bus.done), 32'd0);
    check({tag, "/idle_addr"}, 32'(bus.scratch_mem_read_addr), 32'(BASE));
    if (extra_start) begin
      extra = 0;
      repeat (50) begin
        @(posedge clk); #1;
        if (bus.done) extra++;
      end
      check({tag, "/spurious_done"}, 32'(extra), 32'd0);
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic random_legal();
    logic [15:0] v;
    int p;
    clear_code();
    for (int s = 0; s < 4; s++) begin
      v = 16'($urandom);
      if (v == 16'd0) v = 16'd1;
      if (s < 3) p = s + 5 * $urandom_range(0, 7);
      else       p = 3 + $urandom_range(0, 1) + 5 * $urandom_range(0, 7);
      put(p, v);
    end
  endtask

  task automatic random_any();
    logic [15:0] v;
    int np;
    clear_code();
    np = $urandom_range(0, 7);
    for (int i = 0; i < np; i++) begin
      v = 16'($urandom);
      if (v == 16'd0) v = 16'h8000;
      put($urandom_range(0, 39), v);
    end
  endtask

  initial begin
    int c1, c2, cnt;
    bus.start = 1'b0;
    clear_code();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/done",  32'(bus.done),  32'd0);
    check("rst/index", 32'(bus.index), 32'd0);
    check("rst/sign",  32'(bus.sign),  32'd0);
    check("rst/error", 32'(bus.error), 32'd0);
    check("rst/addr",  32'(bus.scratch_mem_read_addr), 32'(BASE));
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Directed vectors.
    clear_code();
    for (int p = 0; p < 4; p++) put(p, 16'h1FFF);
    run_scan("first4", 1'b1, 1'b0);
    check("first4/idx_const", 32'(bus.index), 32'h0000);
    check("first4/sgn_const", 32'(bus.sign),  32'h000F);

    clear_code();
    put(35, 16'hE000); put(36, 16'h1FFF); put(37, 16'hE000); put(39, 16'h1FFF);
    run_scan("last4", 1'b0, 1'b0);
    check("last4/idx_const", 32'(bus.index), 32'h1FFF);
    check("last4/sgn_const", 32'(bus.sign),  32'h000A);

    clear_code();
    put(10, 16'h0123); put(21, 16'hF000); put(32, 16'h7FFF); put(8, 16'h8001);
    run_scan("mixed", 1'b0, 1'b1);
    check("mixed/idx_const", 32'(bus.index), 32'h05A2);
    check("mixed/sgn_const", 32'(bus.sign),  32'h0005);

    clear_code();
    for (int p = 0; p < 5; p++) put(p, 16'h0400);
    run_scan("five", 1'b0, 1'b0);
    check("five/err_const", 32'(bus.error), 32'd1);

    clear_code();
    for (int p = 0; p < 3; p++) put(p, 16'h0400);
    run_scan("three", 1'b0, 1'b0);
    check("three/err_const", 32'(bus.error), 32'd1);
    check("three/sgn_const", 32'(bus.sign),  32'h0007);

    // Reset in the middle of a scan.
    clear_code();
    put(10, 16'h0123); put(21, 16'hF000); put(32, 16'h7FFF); put(8, 16'h8001);
    run_scan("pre_rst", 1'b0, 1'b0);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst/done",  32'(bus.done),  32'd0);
    check("midrst/index", 32'(bus.index), 32'd0);
    check("midrst/sign",  32'(bus.sign),  32'd0);
    check("midrst/error", 32'(bus.error), 32'd0);
    check("midrst/addr",  32'(bus.scratch_mem_read_addr), 32'(BASE));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.done) cnt++;
    end
    check("midrst/no_done", 32'(cnt), 32'd0);
    run_scan("post_rst", 1'b0, 1'b0);

    // start held high: done every 43 cycles.
    random_legal();
    ref_model();
    @(negedge clk) bus.start = 1'b1;
    wait_done(100, c1);
    check("b2b/first", 32'(c1 > 0), 32'd1);
    wait_done(100, c2);
    check("b2b/period1", 32'(c2), 32'd43);
    wait_done(100, c2);
    bus.start = 1'b0;
    check("b2b/period2", 32'(c2), 32'd43);
    check("b2b/index", 32'(bus.index), 32'(exp_idx));
    check("b2b/sign",  32'(bus.sign),  32'(exp_sgn));
    check("b2b/error", 32'(bus.error), 32'(exp_err));
    repeat (3) @(posedge clk);

    // Randomized vectors.
    for (int i = 0; i < 8; i++) begin
      random_legal();
      run_scan($sformatf("rnd_legal%0d", i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      random_any();
      run_scan($sformatf("rnd_any%0d", i), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
